// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg : shared types and default sizes for the round-robin mux arbiter
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int N_DEF  = 128;
  localparam int AW_DEF = 7;

endpackage

`default_nettype wire

// File: rtl/mux128to1_n.sv
// ---------------------------------------------------------------------------
// mux128to1_n : 128-way combinational word multiplexer, n bits per input
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mux128to1_n #(
  parameter int n = 4
) (
  input  logic [n-1:0] data_i [0:127],
  input  logic [6:0]   sel_i,
  output logic [n-1:0] data_o
);

  assign data_o = data_i[sel_i];

endmodule

`default_nettype wire

// File: rtl/rr_pick_next.sv
// ---------------------------------------------------------------------------
// rr_pick_next : combinational round-robin search starting after last_i
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_pick_next #(
  parameter int N  = 128,
  parameter int AW = 7
) (
  input  logic [N-1:0]  req_i,
  input  logic [AW-1:0] last_i,
  input  logic [AW-1:0] mask_idx_i,
  input  logic          mask_en_i,
  output logic [AW-1:0] win_o,
  output logic          found_o
);

  localparam logic [AW:0] N_EXT = (AW+1)'(N);

  logic [N-1:0]   w_masked;
  logic [AW-1:0]  w_start;
  logic [N-1:0]   w_rot;
  logic [AW-1:0]  w_idx;
  logic [AW:0]    w_sum;

  assign w_masked = req_i & ~(mask_en_i ? (N'(1) << mask_idx_i) : '0);
  assign w_start  = (last_i == AW'(N - 1)) ? '0 : last_i + AW'(1);

  // Bit 0 of the rotated vector is the request at index w_start.
  assign w_rot = N'({w_masked, w_masked} >> w_start);

  always_comb begin
    found_o = 1'b0;
    w_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        found_o = 1'b1;
        w_idx   = AW'(i);
      end
    end
  end

  assign w_sum = {1'b0, w_start} + {1'b0, w_idx};
  assign win_o = (w_sum >= N_EXT) ? AW'(w_sum - N_EXT) : AW'(w_sum);

endmodule

`default_nettype wire

// File: rtl/mux_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux_rr_arbiter : round-robin arbiter sharing one mux read port, with a
//                  valid/ready output holding stage and per-source ack
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mux_rr_arbiter
  import arb_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int n  = 4,
  parameter int AW = AW_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [N-1:0]  req_i,
  input  logic [n-1:0]  data_i [0:N-1],
  output logic [AW-1:0] sel_o,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [n-1:0]  data_o,
  output logic [N-1:0]  ack_o
);

  localparam logic [0:0] S_IDLE = IDLE;
  localparam logic [0:0] S_HOLD = HOLD;

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] sel_q, sel_d;
  logic [AW-1:0] last_q, last_d;
  logic [n-1:0]  data_q, data_d;

  logic          w_hs;
  logic [AW-1:0] w_win;
  logic          w_found;
  logic [n-1:0]  w_mux;

  assign w_hs = (state_q == S_HOLD) && ready_i;

  // The just-accepted winner is masked so a requester that has not yet
  // dropped req_i after its ack cannot be granted twice in a row.
  rr_pick_next #(
    .N  (N),
    .AW (AW)
  ) u_pick (
    .req_i      (req_i),
    .last_i     (last_q),
    .mask_idx_i (sel_q),
    .mask_en_i  (w_hs),
    .win_o      (w_win),
    .found_o    (w_found)
  );

  generate
    if (N == 128) begin : g_mux
      mux128to1_n #(
        .n (n)
      ) u_mux (
        .data_i (data_i),
        .sel_i  (w_win),
        .data_o (w_mux)
      );
    end else begin : g_direct
      assign w_mux = data_i[w_win];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (w_found) begin
          state_d = S_HOLD;
          sel_d   = w_win;
          last_d  = w_win;
          data_d  = w_mux;
        end
      end
      S_HOLD: begin
        if (ready_i) begin
          if (w_found) begin
            sel_d  = w_win;
            last_d = w_win;
            data_d = w_mux;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      last_q  <= AW'(N - 1);
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    ack_o = '0;
    if (w_hs) ack_o[sel_q] = 1'b1;
  end

  assign valid_o = (state_q == S_HOLD);
  assign sel_o   = sel_q;
  assign data_o  = data_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux_rr_arbiter : directed and randomized checks against a reference model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mux_rr_arbiter;

  localparam int N  = 128;
  localparam int NW = 4;
  localparam int AW = 7;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [N-1:0]  req_i;
  logic [NW-1:0] data_i [0:N-1];
  logic [AW-1:0] sel_o;
  logic          valid_o;
  logic          ready_i;
  logic [NW-1:0] data_o;
  logic [N-1:0]  ack_o;

  int errors = 0;
  int checks = 0;

  // Reference model: outstanding word plus the most recent winner.
  bit            m_valid;
  int            m_sel;
  int            m_last;
  logic [NW-1:0] m_data;

  always #5 clk_i = ~clk_i;

  mux_rr_arbiter #(
    .N  (N),
    .n  (NW),
    .AW (AW)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req_i   (req_i),
    .data_i  (data_i),
    .sel_o   (sel_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o),
    .ack_o   (ack_o)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // First requester strictly after 'last' in circular order, skipping 'skip'.
  function automatic int search(input logic [N-1:0] r, input int last, input int skip);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last + k) % N;
      if (r[c] && c != skip) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_sel   = 0;
    m_last  = N - 1;
    m_data  = '0;
  endtask

  // One clock: check the combinational ack, advance the model, check the registers.
  task automatic step(input string tag);
    logic [N-1:0] exp_ack;
    int w;
    #1;
    exp_ack = (m_valid && ready_i) ? (N'(1) << m_sel) : '0;
    check({tag, " ack"}, 128'(ack_o), 128'(exp_ack));
    w = -2;
    if (!m_valid)     w = search(req_i, m_last, -1);
    else if (ready_i) w = search(req_i, m_last, m_sel);
    if (w >= 0) begin
      m_valid = 1;
      m_sel   = w;
      m_last  = w;
      m_data  = data_i[w];
    end else if (w == -1 && m_valid) begin
      m_valid = 0;
    end
    @(posedge clk_i);
    #1;
    check({tag, " valid"}, 128'(valid_o), 128'(m_valid));
    if (m_valid) begin
      check({tag, " sel"},  128'(sel_o),  128'(m_sel));
      check({tag, " data"}, 128'(data_o), 128'(m_data));
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " valid"}, 128'(valid_o), 128'(0));
    check({tag, " sel"},   128'(sel_o),   128'(0));
    check({tag, " data"},  128'(data_o),  128'(0));
    check({tag, " ack"},   128'(ack_o),   128'(0));
  endtask

  task automatic drain();
    req_i   = '0;
    ready_i = 1'b1;
    step("drain");
    step("drain");
  endtask

  initial begin
    rst_i   = 1'b1;
    req_i   = '0;
    ready_i = 1'b0;
    for (int k = 0; k < N; k++) data_i[k] = NW'(k);
    model_reset();
    #2;
    check_zero("reset");
    @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Single request
    req_i      = N'(1) << 5;
    data_i[5]  = 4'hA;
    ready_i    = 1'b1;
    step("single");
    check("single sel", 128'(sel_o), 128'(5));
    check("single data", 128'(data_o), 128'(4'hA));
    #1 check("single ack", 128'(ack_o), 128'(N'(1) << 5));
    req_i = '0;
    step("single");

    // Rotation across three sources, including the top index
    drain();
    req_i = (N'(1) << 3) | (N'(1) << 10) | (N'(1) << 127);
    for (int i = 0; i < 7; i++) step("rotate");

    // Wrap-around after granting 127
    req_i = N'(1) << 127;
    step("wrap");
    req_i = (N'(1) << 0) | (N'(1) << 126);
    step("wrap");
    check("wrap first", 128'(sel_o), 128'(0));
    step("wrap");
    check("wrap second", 128'(sel_o), 128'(126));

    // Backpressure with inputs changing during the stall
    drain();
    req_i     = N'(1) << 7;
    data_i[7] = 4'h5;
    ready_i   = 1'b0;
    step("bp");
    for (int i = 0; i < 4; i++) begin
      data_i[7] = NW'($urandom);
      req_i     = {$urandom(), $urandom(), $urandom(), $urandom()};
      step("bp");
    end
    check("bp frozen data", 128'(data_o), 128'(4'h5));
    ready_i = 1'b1;
    step("bp");

    // Self-mask: sole requester is skipped once after its ack
    drain();
    req_i = N'(1) << 9;
    for (int i = 0; i < 4; i++) step("selfmask");

    // Asynchronous reset while a word is held
    drain();
    req_i   = N'(1) << 20;
    ready_i = 1'b0;
    step("prerst");
    #2 rst_i = 1'b1;
    #1 check_zero("rst mid");
    model_reset();
    @(posedge clk_i);
    #2 rst_i = 1'b0;
    req_i   = (N'(1) << 2) | (N'(1) << 50);
    ready_i = 1'b1;
    step("postrst");
    check("postrst sel", 128'(sel_o), 128'(2));
    step("postrst");

    // Randomized traffic
    for (int cyc = 0; cyc < 600; cyc++) begin
      int mode;
      mode = int'($urandom_range(0, 3));
      case (mode)
        0: req_i = '0;
        1: req_i = N'(1) << $urandom_range(0, N - 1);
        2: req_i = (N'(1) << $urandom_range(0, N - 1)) | (N'(1) << $urandom_range(0, N - 1))
                 | (N'(1) << $urandom_range(0, N - 1));
        default: req_i = {$urandom(), $urandom(), $urandom(), $urandom()};
      endcase
      for (int k = 0; k < N; k++) data_i[k] = NW'($urandom);
      ready_i = ($urandom_range(0, 3) != 0);
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
